// File: rtl/play_timer_ctrl_if.sv
// Command/length inputs and MM:SS, state, tick and done outputs of play_timer_ctrl.
// seek_fwd is present only when TIMER_SEEK_EN is defined.
interface play_timer_ctrl_if;
  logic        start;
  logic        pause;
  logic        stop;
`ifdef TIMER_SEEK_EN
  logic        seek_fwd;
`endif
  logic [15:0] track_len;
  logic [1:0]  state;
  logic [3:0]  sec_l;
  logic [3:0]  sec_h;
  logic [3:0]  min_l;
  logic [3:0]  min_h;
  logic        tick;
  logic        done;

  modport master (
`ifdef TIMER_SEEK_EN
    output seek_fwd,
`endif
    output start, pause, stop, track_len,
    input  state, sec_l, sec_h, min_l, min_h, tick, done
  );

  modport slave (
`ifdef TIMER_SEEK_EN
    input  seek_fwd,
`endif
    input  start, pause, stop, track_len,
    output state, sec_l, sec_h, min_l, min_h, tick, done
  );
endinterface

// File: rtl/play_timer_ctrl.sv
// MM:SS play timer: IDLE/PLAY/PAUSE/DONE with a TICK_DIV prescaler, registered outputs,
// no backpressure (commands are single-cycle pulses). TIMER_SEEK_EN adds a +10 s seek.
module play_timer_ctrl #(
  parameter int unsigned TICK_DIV = 100000000
) (
  input  logic            clk,
  input  logic            rst,
  play_timer_ctrl_if.slave tmr
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PLAY  = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_e;

  localparam int unsigned     PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0]   PRESC_MAX = PW'(TICK_DIV - 1);

  state_e        state_q, state_d;
  logic [15:0]   time_q, time_d;
  logic [15:0]   len_q, len_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          tick_q, tick_d;
  logic          done_q, done_d;
  logic          stepped, seeked, len_ok;

  function automatic logic [7:0] inc_min(input logic [7:0] m);
    logic [3:0] mh, ml;
    {mh, ml} = m;
    if (ml != 4'd9) begin
      ml = ml + 4'd1;
    end else begin
      ml = 4'd0;
      mh = (mh == 4'd5) ? 4'd0 : mh + 4'd1;
    end
    return {mh, ml};
  endfunction

  function automatic logic [15:0] inc_sec(input logic [15:0] t);
    logic [3:0] sh, sl;
    logic [7:0] m;
    {m, sh, sl} = t;
    if (sl != 4'd9) begin
      sl = sl + 4'd1;
    end else begin
      sl = 4'd0;
      if (sh != 4'd5) begin
        sh = sh + 4'd1;
      end else begin
        sh = 4'd0;
        m  = inc_min(m);
      end
    end
    return {m, sh, sl};
  endfunction

  function automatic logic [15:0] add_10s(input logic [15:0] t);
    logic [3:0] sh, sl;
    logic [7:0] m;
    {m, sh, sl} = t;
    if (sh != 4'd5) begin
      sh = sh + 4'd1;
    end else begin
      sh = 4'd0;
      m  = inc_min(m);
    end
    return {m, sh, sl};
  endfunction

  // A length with any out-of-range digit can never equal a legal time, so it is unlimited.
  function automatic logic bcd_legal(input logic [15:0] t);
    return (t[15:12] <= 4'd5) && (t[11:8] <= 4'd9) && (t[7:4] <= 4'd5) && (t[3:0] <= 4'd9);
  endfunction

  assign len_ok = (len_q != 16'h0000) && bcd_legal(len_q);

  always_comb begin
    state_d = state_q;
    time_d  = time_q;
    len_d   = len_q;
    presc_d = presc_q;
    tick_d  = 1'b0;
    done_d  = 1'b0;
    stepped = 1'b0;
    seeked  = 1'b0;
    if (tmr.stop) begin
      state_d = S_IDLE;
      time_d  = 16'h0000;
      presc_d = '0;
    end else if (tmr.start) begin
      state_d = S_PLAY;
      time_d  = 16'h0000;
      presc_d = '0;
      len_d   = tmr.track_len;
    end else begin
      if (state_q == S_PLAY) begin
        if (tmr.pause) begin
          state_d = S_PAUSE;
        end else if (presc_q == PRESC_MAX) begin
          presc_d = '0;
          time_d  = inc_sec(time_q);
          tick_d  = 1'b1;
          stepped = 1'b1;
        end else begin
          presc_d = presc_q + PW'(1);
        end
      end else if (state_q == S_PAUSE && tmr.pause) begin
        state_d = S_PLAY;
      end
`ifdef TIMER_SEEK_EN
      if (tmr.seek_fwd && (state_q == S_PLAY || state_q == S_PAUSE)) begin
        time_d = add_10s(time_d);
        seeked = 1'b1;
      end
`endif
      // A seek may jump past the end, so it clamps; a plain tick only ever lands exactly on it.
      if (len_ok && ((stepped && time_d == len_q) || (seeked && time_d >= len_q))) begin
        time_d  = len_q;
        state_d = S_DONE;
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      time_q  <= 16'h0000;
      len_q   <= 16'h0000;
      presc_q <= '0;
      tick_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      time_q  <= time_d;
      len_q   <= len_d;
      presc_q <= presc_d;
      tick_q  <= tick_d;
      done_q  <= done_d;
    end
  end

  assign tmr.state = state_q;
  assign tmr.min_h = time_q[15:12];
  assign tmr.min_l = time_q[11:8];
  assign tmr.sec_h = time_q[7:4];
  assign tmr.sec_l = time_q[3:0];
  assign tmr.tick  = tick_q;
  assign tmr.done  = done_q;

endmodule

// File: tb/tb_play_timer_ctrl.sv
// Scoreboard bench for play_timer_ctrl with TICK_DIV=4: expected tick/done events are
// queued when commands are driven and popped by a negedge monitor.
module tb_play_timer_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;

  play_timer_ctrl_if tmr ();

  play_timer_ctrl #(.TICK_DIV(4)) dut (
    .clk (clk),
    .rst (rst),
    .tmr (tmr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] t;
    logic        tk;
    logic        dn;
    int          cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc_cnt = 0;
  int   total   = 0;
  int   passed  = 0;

  localparam int C_START     = 0;
  localparam int C_PAUSE     = 1;
  localparam int C_STOP      = 2;
  localparam int C_STOPSTART = 3;
  localparam int C_SEEK      = 4;

  logic [15:0] obs_t;
  assign obs_t = {tmr.min_h, tmr.min_l, tmr.sec_h, tmr.sec_l};

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  always @(negedge clk) begin
    if (tmr.tick === 1'b1 || tmr.done === 1'b1) begin
      total++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_pulse: tick=%0b done=%0b time=%h cyc=%0d, required no pulse",
                 tmr.tick, tmr.done, obs_t, cyc_cnt);
      end else begin
        mon_e = sb.pop_front();
        if (obs_t !== mon_e.t || tmr.tick !== mon_e.tk || tmr.done !== mon_e.dn ||
            (mon_e.cyc >= 0 && cyc_cnt != mon_e.cyc))
          $display("FAIL scoreboard: time=%h tick=%0b done=%0b cyc=%0d, required time=%h tick=%0b done=%0b cyc=%0d",
                   obs_t, tmr.tick, tmr.done, cyc_cnt, mon_e.t, mon_e.tk, mon_e.dn, mon_e.cyc);
        else
          passed++;
      end
    end
  end

  function automatic logic [15:0] to_bcd(input int secs);
    int s, m, x;
    s = secs % 3600;
    m = s / 60;
    x = s % 60;
    return {4'(m / 10), 4'(m % 10), 4'(x / 10), 4'(x % 10)};
  endfunction

  task automatic cmd(input int edge_no, input int which, input logic [15:0] len);
    while (cyc_cnt < edge_no - 1) begin
      @(posedge clk);
      #1;
    end
    case (which)
      C_START:     begin tmr.start = 1'b1; tmr.track_len = len; end
      C_PAUSE:     tmr.pause = 1'b1;
      C_STOP:      tmr.stop = 1'b1;
      C_STOPSTART: begin tmr.stop = 1'b1; tmr.start = 1'b1; tmr.track_len = len; end
`ifdef TIMER_SEEK_EN
      C_SEEK:      tmr.seek_fwd = 1'b1;
`endif
      default:     ;
    endcase
    @(posedge clk);
    #1;
    tmr.start = 1'b0;
    tmr.pause = 1'b0;
    tmr.stop  = 1'b0;
`ifdef TIMER_SEEK_EN
    tmr.seek_fwd = 1'b0;
`endif
  endtask

  task automatic start_play(input logic [15:0] len, output int c0);
    cmd(cyc_cnt + 1, C_START, len);
    c0 = cyc_cnt;
  endtask

  task automatic push_run(input int c0, input int n, input int done_at);
    for (int k = 1; k <= n; k++)
      sb.push_back('{to_bcd(k), 1'b1, logic'(k == done_at), c0 + 4 * k});
  endtask

  task automatic drain(input string name, input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (sb.size() != 0) begin
      $display("FAIL %s_drain: %0d events pending after %0d cycles, required 0", name, sb.size(), budget);
      sb.delete();
    end else begin
      passed++;
    end
  endtask

  task automatic test_reset();
    #12;
    total++; if (tmr.state !== 2'd0) $display("FAIL reset_state: got %0d, required 0", tmr.state); else passed++;
    total++; if (obs_t !== 16'h0000) $display("FAIL reset_time: got %h, required 0000", obs_t); else passed++;
    total++; if (tmr.tick !== 1'b0) $display("FAIL reset_tick: got %b, required 0", tmr.tick); else passed++;
    total++; if (tmr.done !== 1'b0) $display("FAIL reset_done: got %b, required 0", tmr.done); else passed++;
    @(posedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic test_track_end();
    int c0;
    start_play(16'h0003, c0);
    push_run(c0, 3, 3);
    drain("track_end", 40);
    repeat (10) @(negedge clk);
    total++; if (tmr.state !== 2'd3) $display("FAIL end_state: got %0d, required 3", tmr.state); else passed++;
    total++; if (obs_t !== 16'h0003) $display("FAIL end_hold: got %h, required 0003", obs_t); else passed++;
  endtask

  task automatic test_pause();
    int c0, p;
    start_play(16'h0000, c0);
    push_run(c0, 2, 0);
    cmd(c0 + 11, C_PAUSE, 16'h0000);
    repeat (20) @(negedge clk);
    total++; if (tmr.state !== 2'd2) $display("FAIL pause_state: got %0d, required 2", tmr.state); else passed++;
    total++; if (obs_t !== 16'h0002) $display("FAIL pause_hold: got %h, required 0002", obs_t); else passed++;
    p = cyc_cnt + 1;
    sb.push_back('{16'h0003, 1'b1, 1'b0, p + 2});
    cmd(p, C_PAUSE, 16'h0000);
    drain("resume", 20);
    total++; if (tmr.state !== 2'd1) $display("FAIL resume_state: got %0d, required 1", tmr.state); else passed++;
    cmd(cyc_cnt + 1, C_STOP, 16'h0000);
  endtask

  task automatic test_carry();
    int c0;
    start_play(16'h0000, c0);
    push_run(c0, 3600, 0);
    drain("carry", 3600 * 4 + 20);
    total++; if (tmr.state !== 2'd1) $display("FAIL wrap_state: got %0d, required 1", tmr.state); else passed++;
    total++; if (obs_t !== 16'h0000) $display("FAIL wrap_time: got %h, required 0000", obs_t); else passed++;
    cmd(cyc_cnt + 1, C_STOP, 16'h0000);
  endtask

  task automatic test_stop_start();
    int c0;
    start_play(16'h0000, c0);
    push_run(c0, 7, 0);
    drain("pre_stop", 40);
    cmd(c0 + 32, C_STOPSTART, 16'h0005);
    @(negedge clk);
    total++; if (tmr.state !== 2'd0) $display("FAIL stopstart_state: got %0d, required 0", tmr.state); else passed++;
    total++; if (obs_t !== 16'h0000) $display("FAIL stopstart_time: got %h, required 0000", obs_t); else passed++;
    total++; if (tmr.tick !== 1'b0) $display("FAIL stopstart_tick: got %b, required 0", tmr.tick); else passed++;
    repeat (8) @(negedge clk);
    total++; if (tmr.state !== 2'd0) $display("FAIL idle_stays: got %0d, required 0", tmr.state); else passed++;
  endtask

  task automatic test_reset_mid();
    int c0;
    start_play(16'h0000, c0);
    push_run(c0, 83, 0);
    drain("pre_reset", 83 * 4 + 20);
    total++; if (obs_t !== 16'h0123) $display("FAIL pre_reset_time: got %h, required 0123", obs_t); else passed++;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    total++; if (tmr.state !== 2'd0) $display("FAIL async_rst_state: got %0d, required 0", tmr.state); else passed++;
    total++; if (obs_t !== 16'h0000) $display("FAIL async_rst_time: got %h, required 0000", obs_t); else passed++;
    @(posedge clk);
    #2 rst = 1'b0;
    start_play(16'h0000, c0);
    push_run(c0, 2, 0);
    drain("post_reset", 20);
    cmd(cyc_cnt + 1, C_STOP, 16'h0000);
  endtask

  task automatic test_illegal_len();
    int c0;
    start_play(16'h000A, c0);
    push_run(c0, 12, 0);
    drain("illegal_len", 70);
    total++; if (tmr.state !== 2'd1) $display("FAIL illegal_len_state: got %0d, required 1", tmr.state); else passed++;
    cmd(cyc_cnt + 1, C_STOP, 16'h0000);
  endtask

`ifdef TIMER_SEEK_EN
  task automatic test_seek();
    int c0;
    start_play(16'h0000, c0);
    push_run(c0, 5, 0);
    drain("pre_seek", 40);
    cmd(cyc_cnt + 1, C_PAUSE, 16'h0000);
    cmd(cyc_cnt + 1, C_SEEK, 16'h0000);
    @(negedge clk);
    total++; if (obs_t !== 16'h0015) $display("FAIL seek_time: got %h, required 0015", obs_t); else passed++;
    total++; if (tmr.state !== 2'd2) $display("FAIL seek_state: got %0d, required 2", tmr.state); else passed++;
    start_play(16'h0012, c0);
    push_run(c0, 5, 0);
    drain("pre_seek_len", 40);
    cmd(cyc_cnt + 1, C_PAUSE, 16'h0000);
    sb.push_back('{16'h0012, 1'b0, 1'b1, -1});
    cmd(cyc_cnt + 1, C_SEEK, 16'h0000);
    drain("seek_done", 10);
    total++; if (tmr.state !== 2'd3) $display("FAIL seek_len_state: got %0d, required 3", tmr.state); else passed++;
    total++; if (obs_t !== 16'h0012) $display("FAIL seek_len_time: got %h, required 0012", obs_t); else passed++;
  endtask
`endif

  initial begin
    tmr.start     = 1'b0;
    tmr.pause     = 1'b0;
    tmr.stop      = 1'b0;
    tmr.track_len = 16'h0000;
`ifdef TIMER_SEEK_EN
    tmr.seek_fwd  = 1'b0;
`endif
    test_reset();
    test_track_end();
    test_pause();
    test_carry();
    test_stop_start();
    test_reset_mid();
    test_illegal_len();
`ifdef TIMER_SEEK_EN
    test_seek();
`endif
    repeat (4) @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation exceeded time limit, %0d/%0d checks passed", passed, total);
    $fatal(1);
  end

endmodule
